pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with an IDLE/BUSY FSM for multi-cycle EX ops.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned NSTAGE = 6,
    parameter int unsigned EX_IDX = 3,
    parameter int unsigned MC_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_abort,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              mc_timeout
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PC_W   = 32;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MC_MAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_flush;
    logic [PC_W-1:0]    r_new_pc;
    logic               r_abort;
    logic               r_timeout;
    logic               w_abort_nxt;
    logic               w_timeout_nxt;
    logic               w_ex_req;
    logic [NSTAGE-1:0]  w_eff;
    logic [NSTAGE-1:0]  w_mask;

    // State, busy counter and registered pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_flush   <= 1'b0;
            r_new_pc  <= '0;
            r_abort   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flush   <= flush_req;
            r_abort   <= w_abort_nxt;
            r_timeout <= w_timeout_nxt;
            if (flush_req) begin
                r_new_pc <= flush_pc;
            end
        end
    end

    // Next state: flush_req beats mc_done, which beats timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_abort_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (mc_start && !flush_req && !r_flush) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (flush_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_abort_nxt = 1'b1;
                end else if (mc_done) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: EX stall request from the FSM merged into the stage requests
    always_comb begin
        w_ex_req = 1'b0;
        mc_busy  = 1'b0;
        case (r_state)
            S_IDLE:  w_ex_req = mc_start;
            S_BUSY: begin
                w_ex_req = !mc_done;
                mc_busy  = 1'b1;
            end
            default: w_ex_req = 1'b0;
        endcase
        w_eff = stallreq | (NSTAGE'(w_ex_req) << EX_IDX);
    end

    // A stalled stage freezes every stage upstream of it
    for (genvar g = 0; g < NSTAGE; g++) begin : g_mask
        assign w_mask[g] = |w_eff[NSTAGE-1:g];
    end

    assign stall      = r_flush ? '0 : w_mask;
    assign flush      = r_flush;
    assign new_pc     = r_new_pc;
    assign mc_abort   = r_abort;
    assign mc_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (stall[0] && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + PERF_W'(1);
            end
            if (r_flush && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: vector table, hand sequences and random stimulus vs. a reference model.
// Two instances share stimulus: default MC_MAX and MC_MAX=4 for timeout coverage.
module tb_pipe_ctrl;

    localparam int NS  = 6;
    localparam int EXI = 3;
    localparam int MCA = 64;
    localparam int MCB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stallreq;
    logic          flush_req;
    logic [31:0]   flush_pc;
    logic          mc_start;
    logic          mc_done;

    logic [NS-1:0] stall_a, stall_b;
    logic          flush_a, flush_b;
    logic [31:0]   npc_a, npc_b;
    logic          busy_a, busy_b, abort_a, abort_b, to_a, to_b;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   ps_a, pf_a, ps_b, pf_b;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(NS), .EX_IDX(EXI), .MC_MAX(MCA)) u_a (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc(flush_pc), .mc_start(mc_start), .mc_done(mc_done),
        .stall(stall_a), .flush(flush_a), .new_pc(npc_a), .mc_busy(busy_a),
        .mc_abort(abort_a),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc(ps_a), .perf_flush_cnt(pf_a),
`endif
        .mc_timeout(to_a)
    );

    pipe_ctrl #(.NSTAGE(NS), .EX_IDX(EXI), .MC_MAX(MCB)) u_b (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc(flush_pc), .mc_start(mc_start), .mc_done(mc_done),
        .stall(stall_b), .flush(flush_b), .new_pc(npc_b), .mc_busy(busy_b),
        .mc_abort(abort_b),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc(ps_b), .perf_flush_cnt(pf_b),
`endif
        .mc_timeout(to_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance busy flag and elapsed busy cycles
    int          mc_max [2] = '{MCA, MCB};
    bit          m_busy [2];
    int          m_cyc  [2];
    bit          m_abort[2];
    bit          m_to   [2];
    int unsigned m_ps   [2];
    int unsigned m_pf   [2];
    bit          m_flush;
    logic [31:0] m_pc;

    typedef struct {
        logic [NS-1:0] sr;
        logic          fr;
        logic [31:0]   fp;
        logic          ms;
        logic          md;
        logic [NS-1:0] e_stall;
        logic          e_flush;
        logic [31:0]   e_pc;
        logic          e_busy;
        logic          e_abort;
    } vec_t;

    vec_t tbl[$];

    function void add(input logic [NS-1:0] sr, input logic fr, input logic [31:0] fp,
                      input logic ms, input logic md, input logic [NS-1:0] es,
                      input logic ef, input logic [31:0] epc, input logic eb, input logic ea);
        vec_t v;
        v.sr = sr; v.fr = fr; v.fp = fp; v.ms = ms; v.md = md;
        v.e_stall = es; v.e_flush = ef; v.e_pc = epc; v.e_busy = eb; v.e_abort = ea;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Mask of all stages up to the highest requesting one; nothing during a flush
    function automatic logic [NS-1:0] exp_stall(input int n);
        logic [NS-1:0] eff;
        int            k;
        eff = stallreq;
        k   = -1;
        if ((!m_busy[n] && mc_start) || (m_busy[n] && !mc_done))
            eff = eff | NS'(1 << EXI);
        for (int i = 0; i < NS; i++)
            if (((eff >> i) & NS'(1)) != '0) k = i;
        if (k < 0 || m_flush) return '0;
        return NS'((64'd1 << (k + 1)) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 1'b0; m_cyc[n] = 0; m_abort[n] = 1'b0; m_to[n] = 1'b0;
            m_ps[n] = 0; m_pf[n] = 0;
        end
        m_flush = 1'b0;
        m_pc    = '0;
    endtask

    task automatic model_step();
        logic [NS-1:0] s;
        for (int n = 0; n < 2; n++) begin
            s = exp_stall(n);
            if (s[0] && m_ps[n] != 32'hFFFF_FFFF) m_ps[n]++;
            if (m_flush && m_pf[n] != 32'hFFFF_FFFF) m_pf[n]++;
            m_abort[n] = 1'b0;
            m_to[n]    = 1'b0;
            if (m_busy[n]) begin
                if (flush_req) begin
                    m_busy[n] = 1'b0; m_abort[n] = 1'b1;
                end else if (mc_done) begin
                    m_busy[n] = 1'b0;
                end else if (m_cyc[n] == mc_max[n]) begin
                    m_busy[n] = 1'b0; m_to[n] = 1'b1;
                end else begin
                    m_cyc[n]++;
                end
            end else if (mc_start && !flush_req && !m_flush) begin
                m_busy[n] = 1'b1; m_cyc[n] = 1;
            end
        end
        m_flush = flush_req;
        if (flush_req) m_pc = flush_pc;
    endtask

    task automatic check_model();
        chk("stall_a", 32'(stall_a), 32'(exp_stall(0)));
        chk("stall_b", 32'(stall_b), 32'(exp_stall(1)));
        chk("flush_a", 32'(flush_a), 32'(m_flush));
        chk("flush_b", 32'(flush_b), 32'(m_flush));
        if (m_flush) begin
            chk("new_pc_a", npc_a, m_pc);
            chk("new_pc_b", npc_b, m_pc);
        end
        chk("busy_a", 32'(busy_a), 32'(m_busy[0]));
        chk("busy_b", 32'(busy_b), 32'(m_busy[1]));
        chk("abort_a", 32'(abort_a), 32'(m_abort[0]));
        chk("abort_b", 32'(abort_b), 32'(m_abort[1]));
        chk("timeout_a", 32'(to_a), 32'(m_to[0]));
        chk("timeout_b", 32'(to_b), 32'(m_to[1]));
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_a", ps_a, m_ps[0]);
        chk("perf_flush_a", pf_a, m_pf[0]);
        chk("perf_stall_b", ps_b, m_ps[1]);
        chk("perf_flush_b", pf_b, m_pf[1]);
`endif
    endtask

    // Called at posedge+1: apply inputs, check at negedge
    task automatic drive(input logic [NS-1:0] sr, input logic fr, input logic [31:0] fp,
                         input logic ms, input logic md);
        stallreq = sr; flush_req = fr; flush_pc = fp; mc_start = ms; mc_done = md;
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_vals(input string tag, input logic [NS-1:0] es);
        chk({tag, "_stall_a"}, 32'(stall_a), 32'(es));
        chk({tag, "_flush_a"}, 32'(flush_a), 32'd0);
        chk({tag, "_new_pc_a"}, npc_a, 32'd0);
        chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        chk({tag, "_abort_a"}, 32'(abort_a), 32'd0);
        chk({tag, "_timeout_b"}, 32'(to_b), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk({tag, "_perf_stall_a"}, ps_a, 32'd0);
        chk({tag, "_perf_flush_a"}, pf_a, 32'd0);
`endif
    endtask

    initial begin
        logic [NS-1:0] sr;
        logic          fr, ms, md;
        logic [31:0]   fp;

        stallreq = '0; flush_req = 1'b0; flush_pc = '0; mc_start = 1'b0; mc_done = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset", 6'b000000);
        rst = 1'b1;

        // Directed vectors, expectations for the default-MC_MAX instance
        add(6'b000100, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b010100, 1'b0, 32'h0, 1'b0, 1'b0, 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b1, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b000000, 1'b1, 32'hBFC00380, 1'b0, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b100000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b1, 32'hBFC00380, 1'b0, 1'b1);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b1, 32'h00001234, 1'b1, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b1, 32'h00001234, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b1, 32'h000000A0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 6'b000000, 1'b1, 32'h000000A0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b1, 32'h00000100, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b1, 32'h00000200, 1'b0, 1'b0, 6'b000000, 1'b1, 32'h00000100, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b1, 32'h00000200, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b001000, 1'b0, 32'h0, 1'b0, 1'b1, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        add(6'b000000, 1'b1, 32'h0000CAFE, 1'b0, 1'b1, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b1, 32'h0000CAFE, 1'b0, 1'b1);
        add(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].sr, tbl[i].fr, tbl[i].fp, tbl[i].ms, tbl[i].md);
            chk($sformatf("row%0d_stall", i), 32'(stall_a), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d_flush", i), 32'(flush_a), 32'(tbl[i].e_flush));
            if (tbl[i].e_flush) chk($sformatf("row%0d_new_pc", i), npc_a, tbl[i].e_pc);
            chk($sformatf("row%0d_busy", i), 32'(busy_a), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_abort", i), 32'(abort_a), 32'(tbl[i].e_abort));
            chk($sformatf("row%0d_timeout", i), 32'(to_a), 32'd0);
            advance();
        end

        // Timeout on the MC_MAX=4 instance one cycle after its fourth busy cycle
        drive(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        advance();
        for (int c = 1; c <= 4; c++) begin
            drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("to_c%0d_busy_b", c), 32'(busy_b), 32'd1);
            chk($sformatf("to_c%0d_stall_b", c), 32'(stall_b), 32'(6'b001111));
            chk($sformatf("to_c%0d_timeout_b", c), 32'(to_b), 32'd0);
            advance();
        end
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("to_pulse_b", 32'(to_b), 32'd1);
        chk("to_idle_b", 32'(busy_b), 32'd0);
        chk("to_stall_b", 32'(stall_b), 32'd0);
        chk("to_still_busy_a", 32'(busy_a), 32'd1);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("to_pulse_end_b", 32'(to_b), 32'd0);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        advance();

        // Flush on the cycle that would otherwise time out: abort only
        drive(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        advance();
        for (int c = 1; c <= 3; c++) begin
            drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
            advance();
        end
        drive(6'b000000, 1'b1, 32'h00000080, 1'b0, 1'b0);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fvt_abort_b", 32'(abort_b), 32'd1);
        chk("fvt_timeout_b", 32'(to_b), 32'd0);
        chk("fvt_flush_b", 32'(flush_b), 32'd1);
        advance();

        // Reset asserted mid-operation
        drive(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        advance();
        stallreq = 6'b000010;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid", 6'b000011);
        model_reset();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        check_reset_vals("rst_hold", 6'b000011);
        rst = 1'b1;
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        advance();
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        advance();

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            sr = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            fr = ($urandom_range(0, 11) == 0);
            ms = ($urandom_range(0, 4) == 0);
            md = ($urandom_range(0, 6) == 0);
            fp = $urandom;
            drive(sr, fr, fp, ms, md);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
